// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- MIPS decode stage.
//
// Holds the IF/ID pipeline register, a 32x32 register file with one
// write-back port (and same-cycle write-to-read bypass), the instruction
// decoder, and the ID/EX output register. Detects load-use hazards and
// raises a combinational stall request back to fetch.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   Stall               external hold of IF/ID and ID/EX
//   Flush               squash the instruction held in IF/ID
//   IF_Ins, IF_nextPC   instruction and PC+4 from fetch
//   WB_WE/Addr/Data     register-file write-back port
//   LU_Stall            load-use stall request (combinational)
//   ID_*                registered decode results for the execute stage
//
// Handshake: there is no valid/ready pair here. ID_Valid qualifies the
// ID/EX slot. LU_Stall and Stall are hold requests that freeze the
// upstream register(s) for the cycle in which they are high.
// ---------------------------------------------------------------------------
module id_stage #(
   parameter int         REG_COUNT = 32,
   parameter logic [4:0] LINK_REG  = 5'd31
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Stall,
   input  logic        Flush,
   input  logic [31:0] IF_Ins,
   input  logic [31:0] IF_nextPC,
   input  logic        WB_WE,
   input  logic [4:0]  WB_Addr,
   input  logic [31:0] WB_Data,
   output logic        LU_Stall,
   output logic        ID_Valid,
   output logic [31:0] ID_RsData,
   output logic [31:0] ID_RtData,
   output logic [31:0] ID_Imm,
   output logic [4:0]  ID_Dest,
   output logic [5:0]  ID_Op,
   output logic [5:0]  ID_Funct,
   output logic [4:0]  ID_Shamt,
   output logic        ID_RegWrite,
   output logic        ID_MemRead,
   output logic        ID_MemWrite,
   output logic        ID_ALUSrc,
   output logic        ID_Branch,
   output logic        ID_Jump,
   output logic [31:0] ID_JTarget,
   output logic [31:0] ID_nextPC,
   output logic        ID_Illegal
);

   // IF/ID register
   logic        ifid_valid;
   logic [31:0] ifid_ins;
   logic [31:0] ifid_pc;

   // Register file
   logic [31:0] rf [REG_COUNT];

   // Instruction fields
   logic [5:0]  f_op;
   logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
   logic [5:0]  f_funct;
   logic [15:0] f_imm;

   assign f_op    = ifid_ins[31:26];
   assign f_rs    = ifid_ins[25:21];
   assign f_rt    = ifid_ins[20:16];
   assign f_rd    = ifid_ins[15:11];
   assign f_shamt = ifid_ins[10:6];
   assign f_funct = ifid_ins[5:0];
   assign f_imm   = ifid_ins[15:0];

   // Decoder outputs
   logic        dec_rw, dec_mr, dec_mw, dec_as, dec_br, dec_jp;
   logic        dec_illegal, dec_reads_rt;
   logic [4:0]  dec_dest;
   logic [31:0] dec_imm;
   logic [31:0] rs_val, rt_val;
   logic        bubble;

   always_comb begin
      dec_rw       = 1'b0;
      dec_mr       = 1'b0;
      dec_mw       = 1'b0;
      dec_as       = 1'b0;
      dec_br       = 1'b0;
      dec_jp       = 1'b0;
      dec_illegal  = 1'b0;
      dec_reads_rt = 1'b0;
      dec_dest     = 5'd0;
      dec_imm      = {{16{f_imm[15]}}, f_imm};
      case (f_op)
         6'h00: begin dec_dest = f_rd; dec_rw = 1'b1; dec_reads_rt = 1'b1; end
         6'h08, 6'h0A: begin dec_dest = f_rt; dec_rw = 1'b1; dec_as = 1'b1; end
         6'h0C, 6'h0D: begin
            dec_dest = f_rt; dec_rw = 1'b1; dec_as = 1'b1;
            dec_imm  = {16'h0000, f_imm};
         end
         6'h0F: begin
            dec_dest = f_rt; dec_rw = 1'b1; dec_as = 1'b1;
            dec_imm  = {f_imm, 16'h0000};
         end
         6'h23: begin dec_dest = f_rt; dec_rw = 1'b1; dec_mr = 1'b1; dec_as = 1'b1; end
         6'h2B: begin dec_dest = f_rt; dec_mw = 1'b1; dec_as = 1'b1; dec_reads_rt = 1'b1; end
         6'h04, 6'h05: begin dec_dest = f_rt; dec_br = 1'b1; dec_reads_rt = 1'b1; end
         6'h02: dec_jp = 1'b1;
         6'h03: begin dec_jp = 1'b1; dec_rw = 1'b1; dec_dest = LINK_REG; end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Register read with write-back bypass; $0 always reads as zero.
   always_comb begin
      rs_val = rf[f_rs];
      rt_val = rf[f_rt];
      if (WB_WE && (WB_Addr == f_rs)) rs_val = WB_Data;
      if (WB_WE && (WB_Addr == f_rt)) rt_val = WB_Data;
      if (f_rs == 5'd0) rs_val = 32'h0;
      if (f_rt == 5'd0) rt_val = 32'h0;
   end

   // Load in ID/EX whose result is needed by the instruction in IF/ID.
   // The bubble it causes clears ID_Valid, so the request lasts one cycle.
   assign LU_Stall = !RST && ID_Valid && ID_MemRead && (ID_Dest != 5'd0) &&
                     ifid_valid &&
                     ((ID_Dest == f_rs) || (dec_reads_rt && (ID_Dest == f_rt)));

   assign bubble = LU_Stall || Flush || !ifid_valid || dec_illegal;

   // IF/ID register
   always_ff @(posedge CLK) begin
      if (RST || Flush) begin
         ifid_valid <= 1'b0;
         ifid_ins   <= 32'h0;
         ifid_pc    <= 32'h0;
      end else if (!(Stall || LU_Stall)) begin
         ifid_valid <= 1'b1;
         ifid_ins   <= IF_Ins;
         ifid_pc    <= IF_nextPC;
      end
   end

   // Register file; writes proceed even while the pipeline is stalled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < REG_COUNT; i++) rf[i[4:0]] <= 32'h0;
      end else if (WB_WE && (WB_Addr != 5'd0)) begin
         rf[WB_Addr] <= WB_Data;
      end
   end

   // ID/EX register
   always_ff @(posedge CLK) begin
      if (RST || (!Stall && bubble)) begin
         ID_Valid    <= 1'b0;
         ID_RsData   <= 32'h0;
         ID_RtData   <= 32'h0;
         ID_Imm      <= 32'h0;
         ID_Dest     <= 5'd0;
         ID_Op       <= 6'd0;
         ID_Funct    <= 6'd0;
         ID_Shamt    <= 5'd0;
         ID_RegWrite <= 1'b0;
         ID_MemRead  <= 1'b0;
         ID_MemWrite <= 1'b0;
         ID_ALUSrc   <= 1'b0;
         ID_Branch   <= 1'b0;
         ID_Jump     <= 1'b0;
         ID_JTarget  <= 32'h0;
         ID_nextPC   <= 32'h0;
         // Flag only an illegal opcode that would otherwise have issued now.
         ID_Illegal  <= !RST && ifid_valid && dec_illegal && !Flush && !LU_Stall;
      end else if (!Stall) begin
         ID_Valid    <= 1'b1;
         ID_RsData   <= rs_val;
         ID_RtData   <= rt_val;
         ID_Imm      <= dec_imm;
         ID_Dest     <= dec_dest;
         ID_Op       <= f_op;
         ID_Funct    <= f_funct;
         ID_Shamt    <= f_shamt;
         ID_RegWrite <= dec_rw;
         ID_MemRead  <= dec_mr;
         ID_MemWrite <= dec_mw;
         ID_ALUSrc   <= dec_as;
         ID_Branch   <= dec_br;
         ID_Jump     <= dec_jp;
         ID_JTarget  <= {ifid_pc[31:28], ifid_ins[25:0], 2'b00};
         ID_nextPC   <= ifid_pc;
         ID_Illegal  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- scoreboard bench for id_stage. Inputs change on the falling
// edge; a reference model predicts the ID/EX snapshot after the next rising
// edge and queues it; a monitor compares 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_id_stage;

   typedef struct packed {
      logic        v;
      logic [31:0] rs, rt, imm;
      logic [4:0]  dest;
      logic [5:0]  op, funct;
      logic [4:0]  shamt;
      logic        rw, mr, mw, as_, br, jp;
      logic [31:0] jt, npc;
      logic        ill;
      logic        lu;
   } snap_t;

   localparam int W = $bits(snap_t);

   logic CLK = 1'b0;
   logic RST = 1'b1, Stall = 1'b0, Flush = 1'b0, WB_WE = 1'b0;
   logic [31:0] IF_Ins = '0, IF_nextPC = '0, WB_Data = '0;
   logic [4:0]  WB_Addr = '0;
   logic        LU_Stall, ID_Valid, ID_RegWrite, ID_MemRead, ID_MemWrite;
   logic        ID_ALUSrc, ID_Branch, ID_Jump, ID_Illegal;
   logic [31:0] ID_RsData, ID_RtData, ID_Imm, ID_JTarget, ID_nextPC;
   logic [4:0]  ID_Dest, ID_Shamt;
   logic [5:0]  ID_Op, ID_Funct;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // Reference model state
   logic [31:0] m_rf [32];
   logic        m_ifv;
   logic [31:0] m_ins, m_pc;
   snap_t       m_ex;

   id_stage dut (
      .CLK(CLK), .RST(RST), .Stall(Stall), .Flush(Flush),
      .IF_Ins(IF_Ins), .IF_nextPC(IF_nextPC),
      .WB_WE(WB_WE), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
      .LU_Stall(LU_Stall), .ID_Valid(ID_Valid),
      .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
      .ID_Dest(ID_Dest), .ID_Op(ID_Op), .ID_Funct(ID_Funct), .ID_Shamt(ID_Shamt),
      .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
      .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch), .ID_Jump(ID_Jump),
      .ID_JTarget(ID_JTarget), .ID_nextPC(ID_nextPC), .ID_Illegal(ID_Illegal)
   );

   // Clock / reset
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   function automatic bit is_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F,
                        6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
   endfunction

   function automatic bit uses_rt(input logic [5:0] op);
      return op inside {6'h00, 6'h2B, 6'h04, 6'h05};
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] r, input bit we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'h0;
      if (we && wa == r) return wd;
      return m_rf[r];
   endfunction

   function automatic snap_t decode_ref(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] rsv, input logic [31:0] rtv);
      snap_t s = '0;
      logic [5:0] op = ins[31:26];
      s.v = 1'b1; s.op = op; s.funct = ins[5:0]; s.shamt = ins[10:6];
      s.rs = rsv; s.rt = rtv; s.npc = pc;
      s.jt = {pc[31:28], ins[25:0], 2'b00};
      s.imm = {{16{ins[15]}}, ins[15:0]};
      if (op == 6'h0C || op == 6'h0D) s.imm = {16'h0, ins[15:0]};
      if (op == 6'h0F) s.imm = {ins[15:0], 16'h0};
      if (op == 6'h00) begin s.dest = ins[15:11]; s.rw = 1; end
      else if (op == 6'h02) s.jp = 1;
      else if (op == 6'h03) begin s.jp = 1; s.rw = 1; s.dest = 5'd31; end
      else begin
         // I-type: dest=rt, immediate operand except for compare-branches
         s.dest = ins[20:16];
         s.as_  = !(op == 6'h04 || op == 6'h05);
         s.br   = (op == 6'h04 || op == 6'h05);
         s.mr   = (op == 6'h23);
         s.mw   = (op == 6'h2B);
         s.rw   = !(s.br || s.mw);
      end
      return s;
   endfunction

   function automatic bit lu_now();
      logic [4:0] d = m_ex.dest;
      return m_ex.v && m_ex.mr && d != 0 && m_ifv &&
             (d == m_ins[25:21] || (uses_rt(m_ins[31:26]) && d == m_ins[20:16]));
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input bit rst, input bit stall, input bit flush,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd);
      snap_t nx, e;
      bit lu;
      @(negedge CLK);
      RST = rst; Stall = stall; Flush = flush; IF_Ins = ins; IF_nextPC = pc;
      WB_WE = we; WB_Addr = wa; WB_Data = wd;
      lu = lu_now() && !rst;
      if (rst) begin
         m_ex = '0; m_ifv = 0; m_ins = '0; m_pc = '0;
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
      end else begin
         nx = m_ex;
         if (!stall) begin
            if (lu || flush || !m_ifv || !is_legal(m_ins[31:26])) begin
               nx = '0;
               nx.ill = m_ifv && !is_legal(m_ins[31:26]) && !flush && !lu;
            end else begin
               nx = decode_ref(m_ins, m_pc, read_reg(m_ins[25:21], we, wa, wd),
                               read_reg(m_ins[20:16], we, wa, wd));
            end
         end
         if (flush) begin m_ifv = 0; m_ins = '0; m_pc = '0; end
         else if (!(stall || lu)) begin m_ifv = 1; m_ins = ins; m_pc = pc; end
         if (we && wa != 0) m_rf[wa] = wd;
         m_ex = nx;
      end
      e = m_ex;
      e.lu = lu_now();
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [31:0] ins);
      drive(0, 0, 0, ins, 32'h0000_0200, 0, 5'd0, 32'h0);
   endtask

   task automatic spot(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic sample();
      @(posedge CLK);
      #3;
   endtask

   function automatic logic [31:0] rand_ins();
      logic [5:0] ops [16] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23,
                               6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h11};
      logic [31:0] r = $urandom;
      r[31:26] = ops[$urandom_range(0, 15)];
      r[25:21] = 5'($urandom_range(0, 3));
      r[20:16] = 5'($urandom_range(0, 3));
      r[15:11] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   // ---------------- scoreboard monitor ----------------
   initial begin
      snap_t g, e;
      forever begin
         @(posedge CLK);
         #2;
         if (exp_q.size() != 0) begin
            e = snap_t'(exp_q.pop_front());
            g = '{ID_Valid, ID_RsData, ID_RtData, ID_Imm, ID_Dest, ID_Op, ID_Funct,
                  ID_Shamt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_ALUSrc,
                  ID_Branch, ID_Jump, ID_JTarget, ID_nextPC, ID_Illegal, LU_Stall};
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL idex_snapshot t=%0t: got %h expected %h", $time, g, e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      drive(1, 0, 0, 32'h0, 32'h0, 1, 5'd1, 32'hDEAD_BEEF);
      drive(1, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);

      // addi $2,$1,-3 with $1=5
      drive(0, 0, 0, 32'h0, 32'h4, 1, 5'd1, 32'd5);
      drive(0, 0, 0, 32'h2022FFFD, 32'h0000_0100, 0, 5'd0, 32'h0);
      step(32'h0);
      sample();
      spot("addi_rs", ID_RsData, 32'd5);
      spot("addi_imm", ID_Imm, 32'hFFFF_FFFD);
      spot("addi_dest_rw_as", {ID_Dest, ID_RegWrite, ID_ALUSrc}, {5'd2, 2'b11});

      // bypass: write $1=0x1234 while add $4,$3,$1 sits in IF/ID
      step(32'h00612020);
      drive(0, 0, 0, 32'h0, 32'h0, 1, 5'd1, 32'h1234);
      sample();
      spot("bypass_rt", ID_RtData, 32'h1234);
      spot("bypass_dest", ID_Dest, 32'd4);

      // load-use: lw $3,0($2) then add $4,$3,$1
      step(32'h8C430000);
      step(32'h00612020);
      sample();
      spot("lu_raise", LU_Stall, 32'd1);
      step(32'h0);
      sample();
      spot("lu_bubble", {ID_Valid, LU_Stall}, 32'd0);
      step(32'h0);
      sample();
      spot("lu_issue", {ID_Valid, ID_Dest}, {1'b1, 5'd4});

      // ori $5,$0,0x8000 and write to $0
      step(32'h34058000);
      drive(0, 0, 0, 32'h0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
      sample();
      spot("ori_imm", ID_Imm, 32'h0000_8000);
      spot("ori_rs0", ID_RsData, 32'h0);

      // jal, then flush the following instruction
      drive(0, 0, 0, 32'h0C000010, 32'h0000_0104, 0, 5'd0, 32'h0);
      step(32'h00612020);
      sample();
      spot("jal_target", ID_JTarget, 32'h0000_0040);
      spot("jal_dest_jump", {ID_Dest, ID_Jump}, {5'd31, 1'b1});
      drive(0, 0, 1, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      sample();
      spot("flush_bubble", ID_Valid, 32'd0);

      // illegal opcode 0x3F
      step(32'hFC000000);
      step(32'h0);
      sample();
      spot("illegal_flag", {ID_Illegal, ID_Valid}, 32'b10);

      // reset mid-operation
      drive(0, 0, 0, 32'h0, 32'h0, 1, 5'd1, 32'd7);
      step(32'h2022FFFD);
      step(32'h8C430000);
      step(32'h00612020);
      drive(1, 0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0);
      sample();
      spot("rst_ctrl", {ID_Valid, ID_RegWrite, ID_MemRead, ID_Jump, LU_Stall}, 32'd0);
      step(32'h2022FFFD);
      step(32'h0);
      sample();
      spot("rst_reg1", ID_RsData, 32'h0);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         drive($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, rand_ins(), $urandom,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      end
      step(32'h0);
      step(32'h0);
      @(posedge CLK);
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
